// File: rtl/mcu_tx_arbiter.sv
// Round-robin arbiter sharing the single SPI transmit path to the MCU between
// the content-store hit path (req0) and the upstream data return path (req1).
module mcu_tx_arbiter #(
  parameter int PREFIX_W = 64,
  parameter int DATA_W   = 256,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [7:0]          req0_meta,
  input  logic [PREFIX_W-1:0] req0_prefix,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [7:0]          req1_meta,
  input  logic [PREFIX_W-1:0] req1_prefix,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                TX_valid,
  output logic [7:0]          tx_meta,
  output logic [PREFIX_W-1:0] tx_prefix,
  output logic [DATA_W-1:0]   tx_data,
  input  logic                tx_done,
  output logic [1:0]          grant,
  output logic                busy,
  output logic                drop_pulse,
  output logic                timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The counter reaches TIMEOUT-1 on the edge leaving the terminal cycle, so the
  // terminal cycle is the one in which it still reads TIMEOUT-2.
  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;
  logic [1:0]          r_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_drop;
  logic                r_tmo;
  logic [7:0]          r_meta;
  logic [PREFIX_W-1:0] r_prefix;
  logic [DATA_W-1:0]   r_data;

  logic w_sel;
  logic w_accept;
  logic w_drop;
  logic w_launch;
  logic w_tmo;
  logic w_wait_exit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = 1'b0;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_launch    = 1'b0;
    w_tmo       = 1'b0;
    w_wait_exit = 1'b0;
    // With both sources pending, the one that did not win last time goes next.
    w_sel = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept = 1'b1;
          w_drop   = w_sel ? req1_meta[6] : req0_meta[6];
          w_launch = ~w_drop;
          if (w_launch) w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          w_wait_exit = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (r_cnt == LP_TERM) begin
          w_wait_exit = 1'b1;
          w_tmo       = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_grant  <= 2'b00;
      r_cnt    <= '0;
      r_drop   <= 1'b0;
      r_tmo    <= 1'b0;
      r_meta   <= '0;
      r_prefix <= '0;
      r_data   <= '0;
    end else begin
      r_drop <= w_accept & w_drop;
      r_tmo  <= w_tmo;
      if (w_accept) r_last <= w_sel;
      if (w_launch) begin
        r_grant  <= w_sel ? 2'b10 : 2'b01;
        r_meta   <= w_sel ? req1_meta   : req0_meta;
        r_prefix <= w_sel ? req1_prefix : req0_prefix;
        r_data   <= w_sel ? req1_data   : req0_data;
      end
      if (w_wait_exit) r_grant <= 2'b00;
      if (r_state == S_LOAD) r_cnt <= '0;
      else if (r_state == S_WAIT && r_cnt < LP_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign req0_ready  = w_accept & ~w_sel;
  assign req1_ready  = w_accept & w_sel;
  assign TX_valid    = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign grant       = r_grant;
  assign drop_pulse  = r_drop;
  assign timeout_err = r_tmo;
  assign tx_meta     = r_meta;
  assign tx_prefix   = r_prefix;
  assign tx_data     = r_data;

endmodule

// File: doc/mcu_tx_arbiter.md
Name: mcu_tx_arbiter

Overview:
- Shares the single NDN-to-MCU SPI transmit path between two data-packet sources: req0 is the content store hit path and req1 is the upstream data return path.
- Round-robin arbitration; latches the winner's packet fields; issues a 1-cycle TX_valid to the SPI slave; holds the fields stable until the SPI reports frame completion or a watchdog expires.
- Filters out interest packets, because the MCU only receives data packets.

Parameters:
- PREFIX_W, 64, width of the prefix field.
- DATA_W, 256, width of the data payload field.
- TIMEOUT, 1023, maximum WAIT_DONE cycles before abort. Must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  source 0 has a packet
- req0_ready  out  1  source 0 packet accepted this cycle
- req0_meta  in  8  source 0 meta byte; bit6 = type (1 interest, 0 data)
- req0_prefix  in  PREFIX_W  source 0 prefix
- req0_data  in  DATA_W  source 0 payload
- req1_valid, req1_ready, req1_meta, req1_prefix, req1_data: same as source 0, for source 1
- TX_valid  out  1  1-cycle launch pulse to the SPI transmitter
- tx_meta  out  8  latched meta byte
- tx_prefix  out  PREFIX_W  latched prefix
- tx_data  out  DATA_W  latched payload
- tx_done  in  1  SPI pulse: frame fully shifted out
- grant  out  2  one-hot owner of the current transfer; 0 when idle
- busy  out  1  high in any state other than IDLE
- drop_pulse  out  1  1-cycle pulse: interest packet discarded
- timeout_err  out  1  1-cycle pulse: watchdog abort

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; last_grant pointer = 1, so req0 wins first.
- States: IDLE, LOAD, WAIT_DONE, HOLDOFF.
- IDLE, selection:
  - Only req0 valid: select req0. Only req1 valid: select req1.
  - Both valid: select the source not equal to last_grant.
- IDLE, accept handshake:
  - reqN_ready is combinational: 1 only in IDLE and only for the selected source. The transfer occurs on the valid&&ready cycle.
  - Never both readys in the same cycle.
  - Sources must hold their fields stable while valid is high and ready is low.
- IDLE, on acceptance:
  - Selected meta bit6 = 1: discard the packet, drop_pulse = 1 next cycle, update last_grant, stay IDLE.
  - Otherwise: register meta/prefix/data into the tx_* outputs, set grant one-hot, update last_grant, go to LOAD.
- LOAD (exactly 1 cycle):
  - TX_valid = 1.
  - Go to WAIT_DONE with counter = 0.
- WAIT_DONE:
  - Counter increments each cycle.
  - tx_done = 1: go to HOLDOFF.
  - Counter reaches TIMEOUT-1 with tx_done = 0: timeout_err = 1 on the next cycle, go to HOLDOFF.
  - tx_done on that same terminal cycle counts as success; no error is flagged.
- HOLDOFF (exactly 1 cycle):
  - grant cleared to 0; go to IDLE.
  - Guarantees a 1-cycle gap between frames.
- Field stability: tx_meta, tx_prefix, tx_data hold their values from LOAD until the next acceptance. They are not cleared in HOLDOFF.
- tx_done outside WAIT_DONE, including the LOAD cycle, is ignored.
- Timing:
  - Minimum period between accepts: 4 cycles (accept, LOAD, WAIT_DONE ≥ 1, HOLDOFF).
  - TX_valid follows acceptance by exactly 1 cycle.
- Fairness: under continuous dual requests, grants alternate strictly 0, 1, 0, 1, … Dropped interests count as grants.
- Reset mid-operation: return to IDLE immediately; all outputs 0; last_grant = 1; the partially sent SPI frame is not tracked or retried.
- Width rules:
  - Counter width = clog2(TIMEOUT+1).
  - Counter saturates and never wraps, because the state exits at TIMEOUT-1.

Test Plan:
- Single request: req0 valid, meta 0x00, prefix 0x0123456789ABCDEF, data all 0xA5. Expect req0_ready in cycle 0; TX_valid in cycle 1 with those fields; grant = 01. Drive tx_done in cycle 5: busy falls in cycle 7 and the fields are retained.
- Contention: req0 and req1 both valid continuously, tx_done 3 cycles after each TX_valid. Expect grants 0, 1, 0, 1 and no cycle with both readys high.
- Interest filter: req1 valid with meta 0x4A. Expect req1_ready then drop_pulse; TX_valid never asserts; state stays IDLE. The next dual request grants req0.
- Watchdog: TIMEOUT = 8, no tx_done. Expect timeout_err exactly 1 cycle, 8 cycles after TX_valid; then HOLDOFF; then a new accept possible. A second run with tx_done on the terminal cycle expects no timeout_err.
- Spurious done: tx_done pulsed in IDLE and during LOAD. Expect no state change; completion only on the later tx_done in WAIT_DONE.
- Reset mid-transfer: assert rst in WAIT_DONE. Expect all outputs 0 the next cycle; with both requesters valid afterwards, req0 is granted first.
